// File: rtl/ramen_timer_pkg.sv
// Shared definitions for the ramen timer control path.
//   seq_state_t    : sequencer states
//   CLK_HZ_DEF     : board clock frequency (cycles per second)
//   TARGET_SEC_DEF : default brew time in seconds
//   ALARM_SEC_DEF  : default alarm duration in seconds
package ramen_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int CLK_HZ_DEF     = 50_000_000;
  localparam int TARGET_SEC_DEF = 180;
  localparam int ALARM_SEC_DEF  = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 while en is high and emits a
// registered one-cycle tick in the cycle after the wrap.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   en   : advance the counter this cycle
//   clr  : zero the counter and suppress any pending tick
//   tick : one-cycle pulse following each wrap
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // DIV == 1 still needs a one-bit counter that simply stays at zero.
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && (cnt == LAST);
      if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Ramen timer sequencer: start/pause/clear control, 1 s tick generation
// for the digit chain, elapsed-second tracking and the completion alarm.
// CLK_HZ must be even and >= 2; TARGET_SEC and ALARM_SEC must be >= 1.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   btn_start   : start / pause / resume / acknowledge pulse
//   btn_clear   : abort pulse, returns to zero
//   tick_rdy    : one-cycle pulse per elapsed second
//   digits_clr  : one-cycle clear strobe for the digit chain
//   running     : high while in RUN
//   alarm       : high while the alarm is active
//   alarm_blink : alarm gated by a 1 Hz, 50% duty blink
module timer_sequencer
  import ramen_timer_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int TARGET_SEC = TARGET_SEC_DEF,
  parameter int ALARM_SEC  = ALARM_SEC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_clear,
  output logic tick_rdy,
  output logic digits_clr,
  output logic running,
  output logic alarm,
  output logic alarm_blink
);

  localparam int SW = $clog2(TARGET_SEC + 1);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(TARGET_SEC - 1);
  localparam logic [SW-1:0] SEC_MAX  = SW'(TARGET_SEC);
  localparam logic [AW-1:0] ALM_MAX  = AW'(ALARM_SEC);

  seq_state_t    state, state_n;
  logic [SW-1:0] sec_cnt, sec_n;
  logic [AW-1:0] alm_cnt, alm_n;
  logic          alarm_n, blink_n, dclr_n;
  logic          blink_tick;
  logic          sec_en, sec_clr, blink_en, blink_clr;

  // Seconds prescaler holds its partial count through PAUSE and is
  // parked at zero in IDLE and DONE so every start re-times from zero.
  assign sec_en  = (state == RUN);
  assign sec_clr = btn_clear || (state == IDLE) || (state == DONE);

  tick_prescaler #(.DIV(CLK_HZ)) u_sec_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (sec_en),
    .clr  (sec_clr),
    .tick (tick_rdy)
  );

  // The blink timer starts on the DONE entry edge so that its wraps line
  // up with the half-second boundaries of the registered alarm_blink.
  assign blink_en  = (state_n == DONE);
  assign blink_clr = (state_n != DONE);

  tick_prescaler #(.DIV(CLK_HZ / 2)) u_blink_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (blink_en),
    .clr  (blink_clr),
    .tick (blink_tick)
  );

  always_comb begin
    state_n = state;
    sec_n   = sec_cnt;
    alm_n   = alm_cnt;
    dclr_n  = 1'b0;
    if (btn_clear) begin
      state_n = IDLE;
      sec_n   = '0;
      alm_n   = '0;
      dclr_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (btn_start) state_n = RUN;
        end
        RUN, PAUSE: begin
          // A tick can land in the first PAUSE cycle when the pause
          // coincided with a wrap; it still counts, and the last one ends
          // the brew regardless of the button.
          if (tick_rdy && (sec_cnt < SEC_MAX)) sec_n = sec_cnt + 1'b1;
          if (tick_rdy && (sec_cnt == SEC_LAST)) state_n = DONE;
          else if (btn_start) state_n = (state == RUN) ? PAUSE : RUN;
        end
        DONE: begin
          if (btn_start) begin
            state_n = IDLE;
            sec_n   = '0;
            alm_n   = '0;
            dclr_n  = 1'b1;
          end else if (blink_tick && !alarm_blink && (alm_cnt < ALM_MAX)) begin
            // Falling-to-rising blink edge marks a full alarm second.
            alm_n = alm_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    alarm_n = (state_n == DONE) && (alm_n < ALM_MAX);
    blink_n = 1'b0;
    if (alarm_n) begin
      if (state != DONE)   blink_n = 1'b1;
      else if (blink_tick) blink_n = ~alarm_blink;
      else                 blink_n = alarm_blink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sec_cnt     <= '0;
      alm_cnt     <= '0;
      alarm       <= 1'b0;
      alarm_blink <= 1'b0;
      digits_clr  <= 1'b0;
    end else begin
      state       <= state_n;
      sec_cnt     <= sec_n;
      alm_cnt     <= alm_n;
      alarm       <= alarm_n;
      alarm_blink <= blink_n;
      digits_clr  <= dclr_n;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic btn_start;
  logic btn_clear;
  logic tick_rdy;
  logic digits_clr;
  logic running;
  logic alarm;
  logic alarm_blink;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_sequencer #(
    .CLK_HZ     (4),
    .TARGET_SEC (3),
    .ALARM_SEC  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .tick_rdy    (tick_rdy),
    .digits_clr  (digits_clr),
    .running     (running),
    .alarm       (alarm),
    .alarm_blink (alarm_blink)
  );

  typedef struct {
    logic start;
    logic clear;
    logic tick;
    logic dclr;
    logic run;
    logic alm;
    logic blk;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs are applied at a falling edge, sampled at the next rising edge,
  // and outputs are observed at the following falling edge.
  task automatic step(input logic s, input logic c, input logic r);
    btn_start = s;
    btn_clear = c;
    rst       = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string nm, input int idx,
                         input logic t, input logic d, input logic ru,
                         input logic a, input logic b);
    chk({nm, ".tick"},    idx, tick_rdy,    t);
    chk({nm, ".dclr"},    idx, digits_clr,  d);
    chk({nm, ".running"}, idx, running,     ru);
    chk({nm, ".alarm"},   idx, alarm,       a);
    chk({nm, ".blink"},   idx, alarm_blink, b);
  endtask

  // Steps idle cycles until tick_rdy is seen; k = steps taken, -1 on timeout.
  task automatic wait_tick(input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick_rdy === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  // Steps idle cycles until alarm rises, counting ticks on the way.
  task automatic run_to_done(input int lim, output int ticks, output int steps);
    ticks = 0;
    steps = -1;
    for (int i = 1; i <= lim; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick_rdy === 1'b1) ticks++;
      if (alarm === 1'b1) begin
        steps = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ticks, steps;

    // Start, 3 ticks at cycles 5/9/13, DONE with blink 1,1,0,0,1,1,0,0,
    // alarm drop after 8 cycles, then acknowledge.
    for (int i = 0; i <= 12; i++)
      tbl[i] = '{(i == 0), 1'b0, (i == 4 || i == 8 || i == 12), 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 13; i <= 22; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i <= 20),
                 (i <= 20) && (((i - 13) % 4) < 2)};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    btn_start = 1'b0;
    btn_clear = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].start, tbl[i].clear, 1'b0);
      chk_all("tbl", i, tbl[i].tick, tbl[i].dclr, tbl[i].run, tbl[i].alm, tbl[i].blk);
    end

    // Pause after two run cycles, hold, resume: partial second preserved.
    step(1'b1, 1'b0, 1'b0);
    chk("pause.run_start", 0, running, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pause.run_paused", 0, running, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("pause.hold_tick", i, tick_rdy, 1'b0);
      chk("pause.hold_run", i, running, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("pause.resume_run", 0, running, 1'b1);
    wait_tick(10, k);
    chk_int("pause.first_tick_delay", k, 2);
    run_to_done(20, ticks, steps);
    chk_int("pause.remaining_ticks", ticks, 2);
    chk("pause.done_run", 0, running, 1'b0);

    // Acknowledge in DONE, then a full restart.
    step(1'b1, 1'b0, 1'b0);
    chk_all("ack", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("ack.dclr_off", 0, digits_clr, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to_done(30, ticks, steps);
    chk_int("restart.ticks", ticks, 3);
    chk_int("restart.steps", steps, 13);
    chk("restart.blink", 0, alarm_blink, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Clear with simultaneous start exactly on the wrap edge.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("clear", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("clear", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("clear.idle_tick", i, tick_rdy, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    wait_tick(10, k);
    chk_int("clear.retime_delay", k, 4);

    // Reset asserted on the next wrap edge mid-run.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_all("midrst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("midrst.tick", i, tick_rdy, 1'b0);
      chk("midrst.running", i, running, 1'b0);
      chk("midrst.dclr", i, digits_clr, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Control stage directly upstream of the per-digit counter/7-seg decoder chain in the ramen timer.
- Turns the board clock into a 1 s tick pulse that feeds the least-significant digit's carry-in, under start/pause/clear button control.
- Tracks elapsed seconds itself, stops ticking at the target brew time and raises a blinking alarm.
- Also produces the clear strobe that resets the digit chain.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per second. Must be even and at least 2.
- TARGET_SEC, 180, brew time in seconds. Must be at least 1.
- ALARM_SEC, 10, seconds the alarm stays active after completion. Must be at least 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- btn_start  input  1  single-cycle pulse, already debounced: start/pause/resume/acknowledge
- btn_clear  input  1  single-cycle pulse, already debounced: abort and return to zero
- tick_rdy  output  1  one-cycle pulse per elapsed second; drives the lowest digit's carry-in
- digits_clr  output  1  one-cycle pulse; OR'd with rst into the digit chain's reset
- running  output  1  high while in RUN
- alarm  output  1  high while the alarm is active
- alarm_blink  output  1  alarm with a 1 Hz, 50% duty blink; low whenever alarm is low

Behaviour:
- Reset values:
  - state = IDLE
  - pre_cnt = 0, sec_cnt = 0, alm_cnt = 0, blink_cnt = 0
  - all outputs = 0
- Counter widths:
  - pre_cnt: $clog2(CLK_HZ)
  - sec_cnt: $clog2(TARGET_SEC+1)
  - alm_cnt: $clog2(ALARM_SEC+1)
  - All unsigned, with no wrap beyond their stated limits.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- btn_clear, in any state:
  - Next state IDLE; pre_cnt, sec_cnt, alm_cnt and blink_cnt are zeroed.
  - digits_clr = 1 for exactly the next cycle.
  - Wins over a simultaneous btn_start.
- IDLE:
  - btn_start → RUN, with pre_cnt = 0.
- RUN:
  - pre_cnt increments every cycle and wraps at CLK_HZ-1 to 0.
  - On the wrap cycle, tick_rdy = 1 on the following cycle and sec_cnt increments.
  - Timing: btn_start is sampled at edge E0. The first tick_rdy is high during the cycle after edge E0+CLK_HZ. Later ticks follow every CLK_HZ cycles.
  - When the wrap occurs with sec_cnt == TARGET_SEC-1: sec_cnt becomes TARGET_SEC, that final tick_rdy is still issued, and the state moves to DONE.
  - btn_start (without clear) → PAUSE. pre_cnt is held, not cleared. If a wrap coincides with btn_start, the tick is still issued, then the block pauses.
- PAUSE:
  - All counters hold; no ticks.
  - btn_start → RUN, continuing from the held pre_cnt, so partial seconds are preserved.
- DONE:
  - No ticks; sec_cnt holds TARGET_SEC.
  - alarm = 1 while alm_cnt < ALARM_SEC.
  - blink_cnt counts 0..CLK_HZ/2-1. On each wrap, alarm_blink toggles. Each full second, alm_cnt increments, saturating at ALARM_SEC.
  - Once alm_cnt == ALARM_SEC: alarm = 0, alarm_blink = 0, and the state stays DONE so the display keeps showing the final time.
  - btn_start (acknowledge) → IDLE with a one-cycle digits_clr pulse, same as clear.
- Outputs per state:
  - alarm_blink starts high on DONE entry.
  - running = (state == RUN).
  - digits_clr is never asserted during rst.
- Mid-operation reset: takes effect at the next edge, with the reset values above from any state. No tick or digits_clr may appear in the cycle after reset.

Decomposition:
- Package ramen_timer_pkg holds:
  - typedef enum logic [1:0] seq_state_t {IDLE, RUN, PAUSE, DONE}
  - default constants CLK_HZ_DEF and TARGET_SEC_DEF, shared with top level and bench
- One sub-module, tick_prescaler:
  - Parameter DIV.
  - Ports: clk, rst, en, clr, tick.
  - Behaviour: free counter 0..DIV-1 that advances only when en is high; clr zeroes it; tick is a registered one-cycle pulse on wrap.
- Instantiated twice:
  - DIV = CLK_HZ, the seconds prescaler, with en = RUN.
  - DIV = CLK_HZ/2, the blink timer, with en = DONE.

Test Plan (bench overrides CLK_HZ=4, TARGET_SEC=3, ALARM_SEC=2):
- Start from IDLE: pulse btn_start at edge 0 → running = 1 from cycle 1; tick_rdy high in cycles 5, 9 and 13, each one cycle wide; state DONE after the third tick; alarm = 1.
- Pause mid-second: start, then btn_start 2 cycles later, hold 10 cycles, resume → no tick during the pause; first tick arrives 4 run-cycles total after start (3 tick_rdy pulses overall before DONE).
- Alarm: in DONE, alarm_blink toggles every 2 cycles (1,1,0,0,1,1,0,0); after 8 cycles alarm = 0 and alarm_blink = 0; state stays DONE.
- Clear with simultaneous start mid-run → next state IDLE, digits_clr exactly one cycle, no tick_rdy, running = 0, and a later start re-times from zero.
- Acknowledge in DONE with btn_start → IDLE and a digits_clr pulse; a second btn_start restarts a full 3-tick run.
- rst asserted mid-RUN for 1 cycle → all outputs 0 on the next cycle; no tick for at least 4 cycles without a new btn_start.
